fetch_sequencer: RTL
====================

# fetch_sequencer

Sequencer for the pipeline's instruction-fetch stage. It owns the PC, issues requests to instruction memory over a req/ready handshake, and presents fetched instructions to the IF/ID register with valid/stall flow control. It buffers one instruction when decode stalls. It also applies taken-branch redirects from EX and drives the `flush` pulse that squashes the younger instructions, so they cannot write the register file or memory.

## Interface
- `RESET_PC`, 32'h0000_0000, PC value loaded at reset.
- `FLUSH_CYCLES`, 2, number of cycles `flush` stays high per redirect (valid range 1–7).

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `stall`  in  1  IF/ID cannot accept. An instruction transfers on any cycle with `inst_valid`=1 and `stall`=0.
- `redirect`  in  1  taken branch/jump resolved in EX (`branchFlag & zeroFlag`).
- `redirect_target`  in  32  absolute target; bits [1:0] are forced to 0.
- `imem_ready`  in  1  memory returns `imem_rdata` for the outstanding request this cycle.
- `imem_rdata`  in  32  instruction word.
- `imem_req`  out  1  request outstanding; once raised it stays high, with `imem_addr` stable, until `imem_ready`.
- `imem_addr`  out  32  registered request address.
- `inst`  out  32  instruction to IF/ID (registered).
- `inst_pc`  out  32  PC of `inst`.
- `inst_valid`  out  1  `inst` holds a live instruction.
- `flush`  out  1  squash IF/ID and ID/EX contents.
- `redirect_count`  out  16  saturating count of accepted redirects.

## Operation
- State machine states: IDLE, FETCH, SKID, DRAIN, FLUSH.
- Registers: `pc` (next fetch address), `imem_addr`, output register (`inst`, `inst_pc`, `inst_valid`), skid register (data + pc), `flush_cnt` (3 bits). `flush` = (`flush_cnt` != 0).
- An accepted redirect loads `pc` with the target, loads `flush_cnt` with FLUSH_CYCLES, clears `inst_valid` and the skid register, and increments `redirect_count` (saturates at 16'hFFFF).
- IDLE:
  - One cycle after reset release, move to FETCH with `imem_addr`=`pc`.
  - `redirect` is ignored in IDLE.
- FETCH: `imem_req`=1.
  - On `imem_ready` with the output register free (`!inst_valid | !stall`): load the output register with (`imem_rdata`, `imem_addr`). Then `pc`+=4, `imem_addr`=`pc`+4, stay in FETCH.
  - On `imem_ready` with the output register full and `stall`=1: load the skid register, `pc`+=4, go to SKID.
- SKID: `imem_req`=0. When `stall`=0, output register ← skid register, `imem_addr`=`pc`, go to FETCH.
- Redirect priority: `redirect` has priority over `stall`, `imem_ready` and all other state transitions.
  - From FETCH with `imem_ready`=0: go to DRAIN. `imem_req` and the old `imem_addr` stay held.
  - From FETCH with `imem_ready`=1: discard the returned word and go to FLUSH.
  - From SKID or FLUSH: go to FLUSH. The counter restarts and `pc` takes the new target.
  - From DRAIN: stay in DRAIN. `pc` and `flush_cnt` reload.
- DRAIN: `imem_req`=1. On `imem_ready`, discard the data. Then go to FLUSH if `flush_cnt`>1, otherwise go to FETCH with `imem_addr`=`pc`.
- FLUSH: `imem_req`=0 and `flush_cnt` decrements. On the cycle `flush_cnt`==1, go to FETCH with `imem_addr`=`pc`.
- `pc` wraps modulo 2^32 (0xFFFF_FFFC + 4 = 0).

## Timing
- Reset values:
  - state = IDLE; `pc` = `imem_addr` = RESET_PC.
  - `imem_req` = 0, `inst_valid` = 0, `flush` = 0, `flush_cnt` = 0.
  - `inst` = 32'h0000_0013 (NOP); `inst_pc` = RESET_PC; `redirect_count` = 0.
- Reset asserted mid-operation returns every register to these values immediately. Any outstanding request is abandoned.
- First request: `imem_req` rises in the 2nd cycle after `rst` deasserts.
- With zero-wait memory (`imem_ready` = `imem_req`) and `stall`=0: one instruction per cycle. `inst_valid` rises 1 cycle after the first request.
- Redirect accepted on cycle N:
  - `inst_valid`=0 and `flush`=1 from cycle N+1 through N+FLUSH_CYCLES.
  - With no drain, `imem_req`=1 with `imem_addr`=target at cycle N+FLUSH_CYCLES+1.
- Stall: `inst` is held unchanged while `stall`=1. At most one extra word is buffered, and no request is issued while the skid register is full.

## Test plan
- Reset/startup: release `rst`, zero-wait memory, `stall`=0 → `imem_addr` runs 0, 4, 8…; `inst_valid`=1 from the 3rd cycle; `inst_pc` trails `imem_addr` by 1 cycle.
- Stall with skid: assert `stall` for 3 cycles while the word at 0x8 is in the output register → 0xC is captured in the skid register, `imem_req`=0, `inst` stays the 0x8 word. After release: 0xC word, then fetch resumes at 0x10. No word is lost or duplicated.
- Redirect, zero-wait: `redirect`=1 with target 0x100 → `flush`=1 for 2 cycles and `inst_valid`=0. The next request goes to 0x100. `redirect_count`=1.
- Redirect during a slow request: `imem_ready` held low for 4 cycles at 0x20, redirect to 0x40 → `imem_addr` stays 0x20 until ready, the 0x20 data is discarded, and the next request is 0x40.
- Simultaneous `redirect` and `stall` (with the skid register full) → skid cleared, `inst_valid`=0, fetch resumes at the target.
- Back-to-back redirects on consecutive cycles (0x200, then 0x300) → the final fetch goes to 0x300, `flush` stays high for FLUSH_CYCLES cycles after the second redirect, `redirect_count`=2. A target of 0x303 fetches 0x300.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: owns the PC, runs the imem req/ready handshake,
// feeds IF/ID through a one-entry skid buffer and squashes on taken branches.
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_target,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        inst_valid,
    output logic        flush,
    output logic [15:0] redirect_count
);
    localparam logic [31:0] NOP        = 32'h0000_0013;
    localparam logic [2:0]  FLUSH_INIT = 3'(FLUSH_CYCLES);

    typedef enum logic [2:0] {IDLE, FETCH, SKID, DRAIN, FLUSH} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] ipc_q, ipc_d;
    logic        valid_q, valid_d;
    logic [31:0] skid_data_q, skid_data_d;
    logic [31:0] skid_pc_q, skid_pc_d;
    logic [2:0]  fcnt_q, fcnt_d;
    logic [15:0] rcnt_q, rcnt_d;
    logic        req_q, req_d;
    logic        flush_q, flush_d;
    logic [31:0] target;

    assign target = {redirect_target[31:2], 2'b00};

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        addr_d      = addr_q;
        inst_d      = inst_q;
        ipc_d       = ipc_q;
        valid_d     = valid_q;
        skid_data_d = skid_data_q;
        skid_pc_d   = skid_pc_q;
        fcnt_d      = fcnt_q;
        rcnt_d      = rcnt_q;

        // A transfer to IF/ID empties the output register unless refilled below.
        if (valid_q && !stall) valid_d = 1'b0;
        if (fcnt_q != 3'd0)    fcnt_d  = fcnt_q - 3'd1;

        if (redirect && state_q != IDLE) begin
            pc_d        = target;
            fcnt_d      = FLUSH_INIT;
            valid_d     = 1'b0;
            skid_data_d = 32'h0;
            skid_pc_d   = 32'h0;
            if (rcnt_q != 16'hFFFF) rcnt_d = rcnt_q + 16'd1;
            case (state_q)
                // An unanswered request must still complete; hold it in DRAIN.
                FETCH:   state_d = imem_ready ? FLUSH : DRAIN;
                DRAIN:   state_d = DRAIN;
                default: state_d = FLUSH;
            endcase
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = FETCH;
                    addr_d  = pc_q;
                end
                FETCH: begin
                    if (imem_ready) begin
                        pc_d = pc_q + 32'd4;
                        if (!valid_q || !stall) begin
                            inst_d  = imem_rdata;
                            ipc_d   = addr_q;
                            valid_d = 1'b1;
                            addr_d  = pc_q + 32'd4;
                        end else begin
                            skid_data_d = imem_rdata;
                            skid_pc_d   = addr_q;
                            state_d     = SKID;
                        end
                    end
                end
                SKID: begin
                    if (!stall) begin
                        inst_d  = skid_data_q;
                        ipc_d   = skid_pc_q;
                        valid_d = 1'b1;
                        addr_d  = pc_q;
                        state_d = FETCH;
                    end
                end
                DRAIN: begin
                    if (imem_ready) begin
                        if (fcnt_q > 3'd1) begin
                            state_d = FLUSH;
                        end else begin
                            state_d = FETCH;
                            addr_d  = pc_q;
                        end
                    end
                end
                FLUSH: begin
                    if (fcnt_q <= 3'd1) begin
                        state_d = FETCH;
                        addr_d  = pc_q;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        req_d   = (state_d == FETCH) || (state_d == DRAIN);
        flush_d = (fcnt_d != 3'd0);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            pc_q        <= RESET_PC;
            addr_q      <= RESET_PC;
            inst_q      <= NOP;
            ipc_q       <= RESET_PC;
            valid_q     <= 1'b0;
            skid_data_q <= 32'h0;
            skid_pc_q   <= 32'h0;
            fcnt_q      <= 3'd0;
            rcnt_q      <= 16'd0;
            req_q       <= 1'b0;
            flush_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            addr_q      <= addr_d;
            inst_q      <= inst_d;
            ipc_q       <= ipc_d;
            valid_q     <= valid_d;
            skid_data_q <= skid_data_d;
            skid_pc_q   <= skid_pc_d;
            fcnt_q      <= fcnt_d;
            rcnt_q      <= rcnt_d;
            req_q       <= req_d;
            flush_q     <= flush_d;
        end
    end

    assign imem_req       = req_q;
    assign imem_addr      = addr_q;
    assign inst           = inst_q;
    assign inst_pc        = ipc_q;
    assign inst_valid     = valid_q;
    assign flush          = flush_q;
    assign redirect_count = rcnt_q;
endmodule
